rnn_mem_arbiter: RTL and testbench
==================================

Name: rnn_mem_arbiter

Overview:
- Shares the accelerator's single memory port (mce/msel/maddr/mdata_w/mdata_r) between NREQ internal requesters, e.g. the input fetcher, the weight/bias reader and the hidden-state writeback.
- Round-robin arbitration with bounded burst ownership.
- Registered command stage toward memory; read-data return is tagged to the requester that issued the read.
- Sits between the RNN sequencing FSM and the top-level memory pins.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_BURST, 4, max consecutive grants to one owner while others wait (1..16).
- AW, 17, memory address width.
- DW, 20, memory data width.
- SW, 3, memory select (msel) width.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req  in  NREQ  per-requester access request; held with payload until granted
- we  in  NREQ  1 = write (no read return), 0 = read
- sel  in  SW*NREQ  per-requester msel, requester i in slice [i*SW +: SW]
- addr  in  AW*NREQ  per-requester address, slice [i*AW +: AW]
- wdata  in  DW*NREQ  per-requester write data, slice [i*DW +: DW]
- gnt  out  NREQ  one-hot, combinational; requester consumes on this edge
- rvalid  out  NREQ  one-hot; rdata belongs to flagged requester this cycle
- rdata  out  DW  read return (mdata_r passthrough)
- mce  out  1  memory chip enable, registered
- msel  out  SW  memory select, registered
- maddr  out  AW  memory address, registered
- mdata_w  out  DW  memory write data, registered
- mdata_r  in  DW  memory read data, valid 1 cycle after mce

Behaviour:
- Reset: ptr=0, owner=none, burst_cnt=0; mce=0, msel=0, maddr=0, mdata_w=0; gnt=0 and rvalid=0 in reset cycle. In-flight reads are discarded (no rvalid after reset).
- Grant (combinational, from req and registered ptr/owner/burst_cnt), at most one bit:
  - If owner valid, req[owner]=1 and burst_cnt<MAX_BURST: grant owner.
  - Else grant the first set req at or after ptr, searching circularly (ptr, ptr+1, ..., wrap at NREQ-1 -> 0).
  - No req: gnt=0.
- State update on grant to i:
  - i==owner: burst_cnt++.
  - Else: owner=i, burst_cnt=1.
  - Burst limit: when burst_cnt reaches MAX_BURST, or req[owner] drops, ptr=(owner+1) mod NREQ and owner=none. The new owner is chosen the same cycle; other waiters are not stalled for a cycle.
- No grant: owner=none, burst_cnt=0, ptr unchanged.
- Command stage: on the edge where gnt[i]=1, register mce=1, msel=sel_i, maddr=addr_i, mdata_w=wdata_i. If nothing is granted, mce=0 and msel/maddr/mdata_w hold their previous values.
- Read return: a 2-deep shift of {valid, id}, tagged only when we_i=0. rvalid[id]=1 in the cycle mdata_r is valid, i.e. exactly 2 cycles after gnt. rdata=mdata_r always.
- Throughput: one access per cycle; back-to-back reads from different requesters are returned in grant order.
- Simultaneous req from all: service order starts from ptr. With MAX_BURST=1 this is pure round robin.
- req dropped without gnt: allowed, no side effect.
- Requester held in req: never starved; worst-case wait (NREQ-1)*MAX_BURST cycles.

Decomposition:
- Shared package rnn_mem_pkg: AW/DW/SW constants and msel encodings (MSEL_W=000, MSEL_B=001, MSEL_U=010, MSEL_BH=011, MSEL_IN=100, MSEL_OUT=101).
- One sub-module rr_pick: combinational circular first-set finder (req, ptr -> one-hot + index), reusable by other schedulers.

Test Plan:
- Reset, then req=001, we=0, sel0=001, addr0=5.
  - gnt=001 the same cycle; next cycle mce=1, msel=001, maddr=5.
  - Next cycle mdata_r=0x12345 gives rvalid=001, rdata=0x12345.
- All 3 requesters hold req continuously, MAX_BURST=4, ptr=0 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,…
  - rvalid order matches the grant order delayed by 2 cycles.
- req0 drops after 2 grants while req2 waits → third cycle grants 2, ptr becomes 1.
  - With req=101 afterwards, req2 bursts until its limit, then the grant returns to 0.
- Write from requester 1 (we=010, sel=101, addr={t,h}=0x0041, wdata=0xF0000) → mce=1, msel=101, maddr=0x0041, mdata_w=0xF0000; no rvalid 2 cycles later.
- Reset asserted the cycle after a read grant → mce=0 next cycle; rvalid stays 0; ptr=0, and the first post-reset grant goes to the lowest set req.
- Idle (req=0) for 10 cycles → mce=0, gnt=0, and msel/maddr hold their last values.

Source files
------------

// File: rtl/rnn_mem_pkg.sv
// Shared memory-port constants and msel encodings for the RNN accelerator.
package rnn_mem_pkg;

    localparam int MEM_AW = 17;
    localparam int MEM_DW = 20;
    localparam int MEM_SW = 3;

    typedef enum logic [MEM_SW-1:0] {
        MSEL_W   = 3'b000,
        MSEL_B   = 3'b001,
        MSEL_U   = 3'b010,
        MSEL_BH  = 3'b011,
        MSEL_IN  = 3'b100,
        MSEL_OUT = 3'b101
    } msel_e;

endpackage

// File: rtl/rnn_mem_arbiter_if.sv
// Requester-side bus (requesters are master) and memory-side bus (arbiter is master).
interface rnn_mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 17,
    parameter int DW   = 20,
    parameter int SW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [SW*NREQ-1:0] sel;
    logic [AW*NREQ-1:0] addr;
    logic [DW*NREQ-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (output req, we, sel, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, sel, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface rnn_mem_port_if #(
    parameter int AW = 17,
    parameter int DW = 20,
    parameter int SW = 3
);
    logic          mce;
    logic [SW-1:0] msel;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata_w;
    logic [DW-1:0] mdata_r;

    modport master (output mce, msel, maddr, mdata_w, input mdata_r);
    modport slave  (input mce, msel, maddr, mdata_w, output mdata_r);
endinterface

// File: rtl/rnn_mem_arbiter_rr_pick.sv
// Circular first-set finder: lowest set req at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [PW-1:0] j;
            j = PW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one memory port; registered
// command stage and read returns tagged to the issuing requester.
module rnn_mem_arbiter
    import rnn_mem_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 4,
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int SW        = MEM_SW
) (
    input  logic             clk,
    input  logic             reset,
    rnn_mem_arbiter_if.slave req_bus,
    rnn_mem_port_if.master   mem_bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [SW-1:0] sel_arr   [NREQ];
    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign sel_arr[gi]   = req_bus.sel[gi*SW +: SW];
        assign addr_arr[gi]  = req_bus.addr[gi*AW +: AW];
        assign wdata_arr[gi] = req_bus.wdata[gi*DW +: DW];
    end

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          owner_vld_q, owner_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mce_q, mce_d;
    logic [SW-1:0] msel_q, msel_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mdata_w_q, mdata_w_d;
    logic          rd0_vld_q, rd0_vld_d, rd1_vld_q, rd1_vld_d;
    logic [PW-1:0] rd0_id_q, rd0_id_d, rd1_id_q, rd1_id_d;

    logic            keep;
    logic [PW-1:0]   search_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt_vec;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] rvalid_vec;

    // An exhausted or abandoned burst hands the search to the next requester
    // in the same cycle, so waiters never see a bubble.
    always_comb begin
        keep       = owner_vld_q && req_bus.req[owner_q] && (cnt_q < CW'(MAX_BURST));
        search_ptr = ptr_q;
        if (owner_vld_q && !keep) begin
            search_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        end
    end

    rr_pick #(.N(NREQ)) u_pick (
        .req (req_bus.req),
        .ptr (search_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        gnt_vec = '0;
        gnt_idx = pick_idx;
        gnt_any = 1'b0;
        if (!reset) begin
            if (keep) begin
                gnt_vec[owner_q] = 1'b1;
                gnt_idx          = owner_q;
                gnt_any          = 1'b1;
            end else if (pick_any) begin
                gnt_vec = pick_gnt;
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        cnt_d       = cnt_q;
        if (gnt_any) begin
            if (keep) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                ptr_d       = search_ptr;
                owner_d     = gnt_idx;
                owner_vld_d = 1'b1;
                cnt_d       = CW'(1);
            end
        end else begin
            owner_vld_d = 1'b0;
            cnt_d       = '0;
        end

        mce_d     = gnt_any;
        msel_d    = gnt_any ? sel_arr[gnt_idx]   : msel_q;
        maddr_d   = gnt_any ? addr_arr[gnt_idx]  : maddr_q;
        mdata_w_d = gnt_any ? wdata_arr[gnt_idx] : mdata_w_q;

        rd0_vld_d = gnt_any && !req_bus.we[gnt_idx];
        rd0_id_d  = gnt_idx;
        rd1_vld_d = rd0_vld_q;
        rd1_id_d  = rd0_id_q;

        rvalid_vec = '0;
        if (rd1_vld_q && !reset) begin
            rvalid_vec[rd1_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            cnt_q       <= '0;
            mce_q       <= 1'b0;
            msel_q      <= '0;
            maddr_q     <= '0;
            mdata_w_q   <= '0;
            rd0_vld_q   <= 1'b0;
            rd0_id_q    <= '0;
            rd1_vld_q   <= 1'b0;
            rd1_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            cnt_q       <= cnt_d;
            mce_q       <= mce_d;
            msel_q      <= msel_d;
            maddr_q     <= maddr_d;
            mdata_w_q   <= mdata_w_d;
            rd0_vld_q   <= rd0_vld_d;
            rd0_id_q    <= rd0_id_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_id_q    <= rd1_id_d;
        end
    end

    assign req_bus.gnt     = gnt_vec;
    assign req_bus.rvalid  = rvalid_vec;
    assign req_bus.rdata   = mem_bus.mdata_r;
    assign mem_bus.mce     = mce_q;
    assign mem_bus.msel    = msel_q;
    assign mem_bus.maddr   = maddr_q;
    assign mem_bus.mdata_w = mdata_w_q;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Directed bench for rnn_mem_arbiter with a command/read-return scoreboard.
module tb_rnn_mem_arbiter;
    import rnn_mem_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = MEM_AW;
    localparam int DW   = MEM_DW;
    localparam int SW   = MEM_SW;

    typedef struct {
        logic          vld;
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clk;
    logic reset;

    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    we_v;
    logic [SW*NREQ-1:0] sel_v;
    logic [AW*NREQ-1:0] addr_v;
    logic [DW*NREQ-1:0] wdata_v;
    logic [DW-1:0]      mdata_r_v;

    cmd_t cmd_q[$];
    int   rd_q[$];

    logic [SW-1:0] last_sel;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step   = 0;

    rnn_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) bus ();
    rnn_mem_port_if    #(.AW(AW), .DW(DW), .SW(SW))              mem ();

    assign bus.req     = req_v;
    assign bus.we      = we_v;
    assign bus.sel     = sel_v;
    assign bus.addr    = addr_v;
    assign bus.wdata   = wdata_v;
    assign mem.mdata_r = mdata_r_v;

    rnn_mem_arbiter #(.NREQ(NREQ), .MAX_BURST(4), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_bus (bus),
        .mem_bus (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        sel_v[i*SW +: SW]   = s;
        addr_v[i*AW +: AW]  = a;
        wdata_v[i*DW +: DW] = d;
    endtask

    // One cycle: inputs already driven at the falling edge; check, then push
    // the expected command and read return for this cycle's grant.
    task automatic step(input string tag, input logic [NREQ-1:0] exp_gnt, input logic [DW-1:0] md);
        cmd_t            c;
        cmd_t            nc;
        int              rid;
        logic [NREQ-1:0] exp_rv;
        mdata_r_v = md;
        #1;
        chk({tag, ":gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        c = cmd_q.pop_front();
        chk({tag, ":mce"}, 32'(mem.mce), 32'(c.vld));
        if (c.vld) begin
            last_sel   = c.sel;
            last_addr  = c.addr;
            last_wdata = c.wdata;
        end
        chk({tag, ":msel"}, 32'(mem.msel), 32'(last_sel));
        chk({tag, ":maddr"}, 32'(mem.maddr), 32'(last_addr));
        chk({tag, ":mdata_w"}, 32'(mem.mdata_w), 32'(last_wdata));
        rid    = rd_q.pop_front();
        exp_rv = '0;
        if (rid >= 0) exp_rv[rid] = 1'b1;
        chk({tag, ":rvalid"}, 32'(bus.rvalid), 32'(exp_rv));
        if (rid >= 0) chk({tag, ":rdata"}, 32'(bus.rdata), 32'(md));
        $display("step %0d %s req=%b gnt=%b mce=%b maddr=%h rvalid=%b rdata=%h",
                 n_step, tag, req_v, bus.gnt, mem.mce, mem.maddr, bus.rvalid, bus.rdata);
        n_step++;
        nc  = '{vld: 1'b0, sel: '0, addr: '0, wdata: '0};
        rid = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
                nc.vld   = 1'b1;
                nc.sel   = sel_v[i*SW +: SW];
                nc.addr  = addr_v[i*AW +: AW];
                nc.wdata = wdata_v[i*DW +: DW];
                if (!we_v[i]) rid = i;
            end
        end
        cmd_q.push_back(nc);
        rd_q.push_back(rid);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst:gnt", 32'(bus.gnt), 32'd0);
        chk("rst:rvalid", 32'(bus.rvalid), 32'd0);
        $display("reset req=%b gnt=%b rvalid=%b", req_v, bus.gnt, bus.rvalid);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        cmd_q.delete();
        rd_q.delete();
        cmd_q.push_back('{vld: 1'b0, sel: '0, addr: '0, wdata: '0});
        rd_q.push_back(-1);
        rd_q.push_back(-1);
        last_sel   = '0;
        last_addr  = '0;
        last_wdata = '0;
    endtask

    logic [NREQ-1:0] seq_all [14];

    initial begin
        reset     = 1'b1;
        req_v     = '0;
        we_v      = '0;
        sel_v     = '0;
        addr_v    = '0;
        wdata_v   = '0;
        mdata_r_v = '0;

        // Reset with a pending request: grant must stay low.
        req_v = 3'b001;
        set_req(0, MSEL_B, 17'd5, 20'h0);
        do_reset(2);

        // Single read from requester 0.
        step("t1_gnt", 3'b001, 20'h0);
        req_v = '0;
        step("t1_cmd", 3'b000, 20'h0);
        step("t1_ret", 3'b000, 20'h12345);

        // All requesters hold req: bursts of four in round-robin order.
        set_req(0, MSEL_W,  17'h00100, 20'h0);
        set_req(1, MSEL_U,  17'h00101, 20'h0);
        set_req(2, MSEL_IN, 17'h00102, 20'h0);
        we_v    = 3'b000;
        req_v   = 3'b111;
        seq_all = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                    3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001};
        for (int k = 0; k < 14; k++) step("t2_all", seq_all[k], 20'(20'h10000 + k));
        req_v = '0;
        step("t2_drain", 3'b000, 20'h2AAAA);
        step("t2_drain", 3'b000, 20'h25555);

        // Owner 0 drops after two grants while requester 2 waits.
        req_v = 3'b101;
        step("t3_r0", 3'b001, 20'h30001);
        step("t3_r0", 3'b001, 20'h30002);
        req_v = 3'b100;
        step("t3_sw2", 3'b100, 20'h30003);
        req_v = 3'b101;
        step("t3_b2", 3'b100, 20'h30004);
        step("t3_b2", 3'b100, 20'h30005);
        step("t3_b2", 3'b100, 20'h30006);
        step("t3_back0", 3'b001, 20'h30007);
        req_v = '0;
        step("t3_drain", 3'b000, 20'h30008);
        step("t3_drain", 3'b000, 20'h30009);

        // Write from requester 1: command issued, no read return.
        set_req(1, MSEL_OUT, 17'h00041, 20'hF0000);
        we_v  = 3'b010;
        req_v = 3'b010;
        step("t4_wr", 3'b010, 20'h40001);
        req_v = '0;
        step("t4_cmd", 3'b000, 20'h40002);
        step("t4_noret", 3'b000, 20'h40003);

        // Reset right after a read grant discards the in-flight return.
        we_v = 3'b000;
        set_req(2, MSEL_BH, 17'h1FFFF, 20'h0);
        req_v = 3'b100;
        step("t5_rd", 3'b100, 20'h50001);
        req_v = 3'b110;
        do_reset(1);
        step("t5_post", 3'b010, 20'h50002);
        step("t5_post", 3'b010, 20'h50003);

        // Idle: command bus holds the last granted payload.
        req_v = '0;
        for (int k = 0; k < 10; k++) step("t6_idle", 3'b000, 20'(20'h60000 + k));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
